// File: rtl/lsu_wb_master.sv
// Core load/store to Wishbone classic bridge: one single-beat bus cycle per request,
// big-endian byte lanes, sign/zero extension on loads, misalign and timeout errors.
module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_ASYNC,
    input  logic        CORE_REQ_IN,
    input  logic        CORE_WE_IN,
    input  logic [1:0]  CORE_SIZE_IN,
    input  logic        CORE_SIGNED_IN,
    input  logic [31:0] CORE_ADR_IN,
    input  logic [31:0] CORE_DAT_WR_IN,
    output logic        CORE_STALL_OUT,
    output logic        CORE_DONE_OUT,
    output logic        CORE_ERR_OUT,
    output logic [31:0] CORE_DAT_RD_OUT,
    output logic        WB_CYC_OUT,
    output logic        WB_STB_OUT,
    output logic [31:0] WB_ADR_OUT,
    output logic [3:0]  WB_SEL_OUT,
    output logic        WB_WE_OUT,
    output logic [31:0] WB_DAT_WR_OUT,
    input  logic        WB_ACK_IN,
    input  logic [31:0] WB_DAT_RD_IN
);

    typedef enum logic [1:0] {IDLE, BUS, ERR} state_e;

    localparam bit       TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        cyc_q, we_q, signed_q, done_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [3:0]  sel_q;
    logic [7:0]  tmo_q;
    logic [31:0] adr_q, wdat_q, rdat_q;

    logic        misalign_d;
    logic [3:0]  sel_d;
    logic [31:0] wdat_d, rd_ext_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        misalign_d = (CORE_SIZE_IN == 2'b11) ||
                     (CORE_SIZE_IN == 2'b01 && CORE_ADR_IN[0]) ||
                     (CORE_SIZE_IN == 2'b10 && CORE_ADR_IN[1:0] != 2'b00);
        case (CORE_SIZE_IN)
            2'b00: begin
                sel_d  = 4'b1000 >> CORE_ADR_IN[1:0];
                wdat_d = {4{CORE_DAT_WR_IN[7:0]}};
            end
            2'b01: begin
                sel_d  = CORE_ADR_IN[1] ? 4'b0011 : 4'b1100;
                wdat_d = {2{CORE_DAT_WR_IN[15:0]}};
            end
            default: begin
                sel_d  = 4'b1111;
                wdat_d = CORE_DAT_WR_IN;
            end
        endcase
    end

    // Byte offset 0 lives in the most significant lane.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = WB_DAT_RD_IN[31:24];
            2'd1:    rd_byte = WB_DAT_RD_IN[23:16];
            2'd2:    rd_byte = WB_DAT_RD_IN[15:8];
            default: rd_byte = WB_DAT_RD_IN[7:0];
        endcase
        rd_half = off_q[1] ? WB_DAT_RD_IN[15:0] : WB_DAT_RD_IN[31:16];
        case (size_q)
            2'b00:   rd_ext_d = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext_d = {{16{signed_q & rd_half[15]}}, rd_half};
            default: rd_ext_d = WB_DAT_RD_IN;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            sel_q    <= 4'b0000;
            tmo_q    <= 8'h00;
            adr_q    <= 32'h0;
            wdat_q   <= 32'h0;
            rdat_q   <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (CORE_REQ_IN) begin
                    we_q     <= CORE_WE_IN;
                    size_q   <= CORE_SIZE_IN;
                    signed_q <= CORE_SIGNED_IN;
                    off_q    <= CORE_ADR_IN[1:0];
                    adr_q    <= {2'b00, CORE_ADR_IN[31:2]};
                    sel_q    <= sel_d;
                    wdat_q   <= wdat_d;
                    tmo_q    <= 8'h00;
                    if (misalign_d) begin
                        state_q <= ERR;
                    end else begin
                        state_q <= BUS;
                        cyc_q   <= 1'b1;
                    end
                end
                BUS: begin
                    // ACK takes priority over a timeout landing in the same cycle.
                    if (WB_ACK_IN) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q) rdat_q <= rd_ext_d;
                    end else if (TMO_EN && tmo_q == TMO_LAST) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'h01;
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CORE_STALL_OUT  = (state_q != IDLE);
    assign CORE_DONE_OUT   = done_q;
    assign CORE_ERR_OUT    = err_q;
    assign CORE_DAT_RD_OUT = rdat_q;
    assign WB_CYC_OUT      = cyc_q;
    assign WB_STB_OUT      = cyc_q;
    assign WB_ADR_OUT      = adr_q;
    assign WB_SEL_OUT      = sel_q;
    assign WB_WE_OUT       = we_q;
    assign WB_DAT_WR_OUT   = wdat_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Bench for lsu_wb_master: byte-lane RAM slave with programmable wait states,
// vector table plus back-to-back and mid-transaction reset sequences.
module tb_lsu_wb_master;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          ws;
        bit          noack;
        logic [3:0]  sel;
        logic [31:0] bdat;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          ncyc;
        int          t0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, sgn = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        stall, done, err, cyc, stb, wbwe, ack;
    logic [31:0] rdat, wbadr, wbdw, wbdr;
    logic [3:0]  sel;

    int checks = 0, failures = 0, cyc_cnt = 0;
    int ws_cfg = 0, wcnt = 0;
    bit noack_cfg = 1'b0;
    logic [31:0] mem [0:255];
    vec_t sb_q[$];
    vec_t tbl[17];

    lsu_wb_master #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(clk), .RST_ASYNC(rst),
        .CORE_REQ_IN(req), .CORE_WE_IN(we), .CORE_SIZE_IN(size), .CORE_SIGNED_IN(sgn),
        .CORE_ADR_IN(adr), .CORE_DAT_WR_IN(wdat),
        .CORE_STALL_OUT(stall), .CORE_DONE_OUT(done), .CORE_ERR_OUT(err),
        .CORE_DAT_RD_OUT(rdat),
        .WB_CYC_OUT(cyc), .WB_STB_OUT(stb), .WB_ADR_OUT(wbadr), .WB_SEL_OUT(sel),
        .WB_WE_OUT(wbwe), .WB_DAT_WR_OUT(wbdw), .WB_ACK_IN(ack), .WB_DAT_RD_IN(wbdr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign wbdr = mem[wbadr[7:0]];

    // RAM slave: ACK after ws_cfg wait states, drops ACK on a held STB.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack <= 1'b0;
            wcnt <= 0;
            mem[8'h40] <= 32'h11223344;
            mem[8'h41] <= 32'h112233F4;
            mem[8'h42] <= 32'h80011234;
        end else if (cyc && stb && !ack) begin
            if (!noack_cfg && wcnt == ws_cfg) begin
                ack <= 1'b1;
                wcnt <= 0;
                if (wbwe) begin
                    if (sel[3]) mem[wbadr[7:0]][31:24] <= wbdw[31:24];
                    if (sel[2]) mem[wbadr[7:0]][23:16] <= wbdw[23:16];
                    if (sel[1]) mem[wbadr[7:0]][15:8]  <= wbdw[15:8];
                    if (sel[0]) mem[wbadr[7:0]][7:0]   <= wbdw[7:0];
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ack <= 1'b0;
            wcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input int wst,
                                input bit na, input logic [3:0] sl, input logic [31:0] bd,
                                input logic [31:0] r, input logic e, input int l, input int n);
        vec_t v;
        v.we = w; v.size = sz; v.sgn = sg; v.adr = a; v.wdat = wd; v.ws = wst;
        v.noack = na; v.sel = sl; v.bdat = bd; v.rd = r; v.err = e; v.lat = l;
        v.ncyc = n; v.t0 = 0;
        return v;
    endfunction

    // Drives one request, then watches the bus until DONE and scores it.
    // With b2b set the request is raised immediately (caller is in a DONE cycle).
    task automatic apply(input vec_t v, input bit b2b);
        vec_t e;
        int   ncyc = 0;
        bit   got = 1'b0;
        if (!b2b) begin @(posedge clk); #1; end
        ws_cfg = v.ws; noack_cfg = v.noack;
        req = 1'b1; we = v.we; size = v.size; sgn = v.sgn; adr = v.adr; wdat = v.wdat;
        v.t0 = cyc_cnt;
        sb_q.push_back(v);
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cyc !== stb) chk("cyc_eq_stb", {31'b0, stb}, {31'b0, cyc});
            if (cyc) begin
                ncyc++;
                if (ncyc == 1) begin
                    chk("wb_adr", wbadr, {2'b00, sb_q[0].adr[31:2]});
                    chk("wb_sel", {28'b0, sel}, {28'b0, sb_q[0].sel});
                    chk("wb_we", {31'b0, wbwe}, {31'b0, sb_q[0].we});
                    if (sb_q[0].we) chk("wb_dat_wr", wbdw, sb_q[0].bdat);
                end
            end
            if (done) begin
                got = 1'b1;
                e = sb_q.pop_front();
                chk("latency", 32'(cyc_cnt - e.t0), 32'(e.lat));
                chk("cyc_cycles", 32'(ncyc), 32'(e.ncyc));
                chk("err", {31'b0, err}, {31'b0, e.err});
                chk("dat_rd", rdat, e.rd);
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL done_timeout: no DONE within 40 cycles, adr %h", v.adr);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        //              we  sz    sg  adr         wdat          ws na sel      bdat          rd            er lat n
        tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        0, 0, 4'b1111, 32'h0,        32'h11223344, 0, 3, 2);
        tbl[1]  = mk(0, 2'd0, 1, 32'h107, 32'h0,        0, 0, 4'b0001, 32'h0,        32'hFFFFFFF4, 0, 3, 2);
        tbl[2]  = mk(0, 2'd0, 0, 32'h107, 32'h0,        0, 0, 4'b0001, 32'h0,        32'h000000F4, 0, 3, 2);
        tbl[3]  = mk(0, 2'd1, 1, 32'h108, 32'h0,        0, 0, 4'b1100, 32'h0,        32'hFFFF8001, 0, 3, 2);
        tbl[4]  = mk(0, 2'd1, 1, 32'h10A, 32'h0,        0, 0, 4'b0011, 32'h0,        32'h00001234, 0, 3, 2);
        tbl[5]  = mk(1, 2'd1, 0, 32'h102, 32'h0000ABCD, 1, 0, 4'b0011, 32'hABCDABCD, 32'h00001234, 0, 4, 3);
        tbl[6]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        1, 0, 4'b1111, 32'h0,        32'h1122ABCD, 0, 4, 3);
        tbl[7]  = mk(1, 2'd0, 0, 32'h101, 32'hFFFFFF5A, 0, 0, 4'b0100, 32'h5A5A5A5A, 32'h1122ABCD, 0, 3, 2);
        tbl[8]  = mk(0, 2'd0, 0, 32'h101, 32'h0,        0, 0, 4'b0100, 32'h0,        32'h0000005A, 0, 3, 2);
        tbl[9]  = mk(0, 2'd2, 0, 32'h101, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000005A, 1, 2, 0);
        tbl[10] = mk(1, 2'd1, 0, 32'h103, 32'h1234,     0, 0, 4'b0000, 32'h0,        32'h0000005A, 1, 2, 0);
        tbl[11] = mk(0, 2'd3, 0, 32'h100, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0000005A, 1, 2, 0);
        tbl[12] = mk(0, 2'd0, 1, 32'h102, 32'h0,        0, 0, 4'b0010, 32'h0,        32'hFFFFFFAB, 0, 3, 2);
        tbl[13] = mk(0, 2'd2, 0, 32'h100, 32'h0,        0, 1, 4'b1111, 32'h0,        32'hFFFFFFAB, 1, 5, 4);
        tbl[14] = mk(0, 2'd2, 0, 32'h100, 32'h0,        2, 0, 4'b1111, 32'h0,        32'h115AABCD, 0, 5, 4);
        tbl[15] = mk(1, 2'd2, 0, 32'h108, 32'hCAFEF00D, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h115AABCD, 0, 3, 2);
        tbl[16] = mk(0, 2'd1, 0, 32'h108, 32'h0,        0, 0, 4'b1100, 32'h0,        32'h0000CAFE, 0, 3, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {31'b0, cyc}, 32'h0);
        chk("rst_done_err", {30'b0, done, err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_dat_rd", rdat, 32'h0);
        chk("rst_bus", {wbadr[27:0], sel}, 32'h0);
        chk("rst_wr", wbdw, 32'h0);
        chk("rst_we_stb", {30'b0, wbwe, stb}, 32'h0);

        for (int i = 0; i < 17; i++) apply(tbl[i], 1'b0);

        // Back-to-back: second request raised in the first one's DONE cycle.
        apply(mk(0, 2'd2, 0, 32'h104, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h112233F4, 0, 3, 2), 1'b0);
        apply(mk(0, 2'd2, 0, 32'h108, 32'h0, 0, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 3, 2), 1'b1);

        // Reset asserted between edges while the bus cycle is open.
        @(posedge clk); #1;
        noack_cfg = 1'b1;
        req = 1'b1; we = 1'b0; size = 2'd2; sgn = 1'b0; adr = 32'h100;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #3;
        chk("pre_rst_cyc", {31'b0, cyc}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cyc_stb", {30'b0, cyc, stb}, 32'h0);
        chk("mid_rst_done_stall", {30'b0, done, stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dat_rd", rdat, 32'h0);
        apply(mk(0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 4'b1111, 32'h0, 32'h11223344, 0, 3, 2), 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
